// File: rtl/conv3x3_frame_scheduler_pkg.sv
// conv3x3_frame_scheduler_pkg: shared frame geometry and scheduler state encoding
package conv3x3_frame_scheduler_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int IMG_WIDTH = 28;
  localparam int IN_PIX = IMG_WIDTH * IMG_WIDTH;
  localparam int OUT_PIX = (IMG_WIDTH - 2) * (IMG_WIDTH - 2);
  typedef enum logic [2:0] {S_IDLE, S_FLUSH, S_FEED, S_DRAIN, S_DONE} state_t;
endpackage

// File: rtl/conv3x3_frame_scheduler_out_writer.sv
// conv3x3_frame_scheduler_out_writer: counts engine outputs per frame and drives the registered destination write port
//   clear/clear_err: restart out_cnt for a new frame / drop the sticky overflow flag
//   en/kill: capture window and same-cycle write suppression
//   full: out_cnt has reached OUT_PIX; ovf: an output arrived while full
module conv3x3_frame_scheduler_out_writer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_W = 16,
  parameter int OUT_PIX = 676
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  clear_err,
  input  logic                  en,
  input  logic                  kill,
  input  logic [ADDR_W-1:0]     base,
  input  logic                  valid,
  input  logic [DATA_WIDTH-1:0] pixel,
  output logic                  full,
  output logic                  ovf,
  output logic                  wr_en,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data
);
  localparam int CW = $clog2(OUT_PIX + 1);
  logic [CW-1:0] cnt;
  logic wr_q, take;
  assign full = cnt == CW'(OUT_PIX);
  assign take = en & valid & ~full;
  assign wr_en = wr_q & ~kill;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      ovf <= 1'b0;
      wr_q <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_q <= take;
      if (take) begin
        wr_addr <= base + ADDR_W'(cnt);
        wr_data <= pixel;
      end
      cnt <= clear ? '0 : cnt + CW'(take);
      ovf <= ~clear_err & (ovf | (en & valid & full));
    end
  end
endmodule

// File: rtl/conv3x3_frame_scheduler.sv
// conv3x3_frame_scheduler: streams a batch of frames from a source RAM through a 3x3 conv engine into a destination RAM
//   start/abort/num_frames: batch control; busy/done/error: batch status
//   src_rd_*: 1-cycle-latency source RAM read port
//   eng_*: engine reset, pixel stream in, result stream out
//   dst_wr_*: destination RAM write port
module conv3x3_frame_scheduler #(
  parameter int DATA_WIDTH = conv3x3_frame_scheduler_pkg::DATA_WIDTH,
  parameter int IMG_WIDTH = conv3x3_frame_scheduler_pkg::IMG_WIDTH,
  parameter int ADDR_W = 16,
  parameter int FRAME_W = 8,
  parameter int FLUSH_CYC = 2,
  parameter int DRAIN_TIMEOUT = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [FRAME_W-1:0]    num_frames,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic                  src_rd_en,
  output logic [ADDR_W-1:0]     src_rd_addr,
  input  logic [DATA_WIDTH-1:0] src_rd_data,
  output logic                  eng_rst_n,
  output logic                  eng_valid_in,
  output logic [DATA_WIDTH-1:0] eng_pixel_in,
  input  logic                  eng_valid_out,
  input  logic [DATA_WIDTH-1:0] eng_pixel_out,
  output logic                  dst_wr_en,
  output logic [ADDR_W-1:0]     dst_wr_addr,
  output logic [DATA_WIDTH-1:0] dst_wr_data
);
  import conv3x3_frame_scheduler_pkg::*;
  localparam int N_IN = IMG_WIDTH * IMG_WIDTH;
  localparam int N_OUT = (IMG_WIDTH - 2) * (IMG_WIDTH - 2);
  localparam int PW = $clog2(N_IN);
  localparam int CW = $clog2(DRAIN_TIMEOUT + 1);
  state_t state_q, state_d;
  logic [PW-1:0] pix_cnt;
  logic [CW-1:0] cyc;
  logic [FRAME_W-1:0] nf_q, frame_idx;
  logic [ADDR_W-1:0] src_base, dst_base;
  logic err_q, rd_q, zero_done, eng_rst_q, full, ovf;
  logic idle, flush, feed, drain, accept, frame_end, timeout;
  always_comb begin
    idle = state_q == S_IDLE;
    flush = state_q == S_FLUSH;
    feed = state_q == S_FEED;
    drain = state_q == S_DRAIN;
    accept = idle & start & ~abort;
    frame_end = drain & full;
    timeout = drain & ~full & (cyc == CW'(DRAIN_TIMEOUT - 1));
    state_d = abort ? S_IDLE :
              idle  ? ((start && num_frames != '0) ? S_FLUSH : S_IDLE) :
              flush ? ((cyc == CW'(FLUSH_CYC - 1)) ? S_FEED : S_FLUSH) :
              feed  ? ((pix_cnt == PW'(N_IN - 1)) ? S_DRAIN : S_FEED) :
              drain ? (frame_end ? ((frame_idx + 1'b1 < nf_q) ? S_FLUSH : S_DONE) :
                       timeout ? S_DONE : S_DRAIN) :
              S_IDLE;
  end
  // cyc counts cycles spent in the current state: flush length and drain watchdog share it
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cyc <= '0;
      pix_cnt <= '0;
      nf_q <= '0;
      frame_idx <= '0;
      src_base <= '0;
      dst_base <= '0;
      err_q <= 1'b0;
      rd_q <= 1'b0;
      zero_done <= 1'b0;
      eng_rst_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc <= (state_d == state_q) ? cyc + 1'b1 : '0;
      pix_cnt <= feed ? pix_cnt + 1'b1 : '0;
      rd_q <= src_rd_en;
      eng_rst_q <= ~abort & (state_d != S_FLUSH);
      zero_done <= accept & (num_frames == '0);
      if (accept) begin
        nf_q <= num_frames;
        frame_idx <= '0;
        src_base <= '0;
        dst_base <= '0;
        err_q <= 1'b0;
      end
      if (frame_end) begin
        frame_idx <= frame_idx + 1'b1;
        src_base <= src_base + ADDR_W'(N_IN);
        dst_base <= dst_base + ADDR_W'(N_OUT);
      end
      if (timeout) err_q <= 1'b1;
    end
  end
  assign busy = ~idle;
  assign done = (state_q == S_DONE) | zero_done;
  assign error = err_q | ovf;
  assign src_rd_en = feed & ~abort;
  assign src_rd_addr = src_base + ADDR_W'(pix_cnt);
  assign eng_rst_n = eng_rst_q;
  assign eng_valid_in = rd_q & ~abort;
  assign eng_pixel_in = eng_valid_in ? src_rd_data : '0;
  conv3x3_frame_scheduler_out_writer #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_W(ADDR_W),
    .OUT_PIX(N_OUT)
  ) u_writer (
    .clk(clk),
    .rst(rst),
    .clear(flush),
    .clear_err(accept),
    .en((feed | drain) & ~abort),
    .kill(abort),
    .base(dst_base),
    .valid(eng_valid_out),
    .pixel(eng_pixel_out),
    .full(full),
    .ovf(ovf),
    .wr_en(dst_wr_en),
    .wr_addr(dst_wr_addr),
    .wr_data(dst_wr_data)
  );
endmodule

// File: tb/tb_conv3x3_frame_scheduler.sv
// tb_conv3x3_frame_scheduler: scoreboard bench with source RAM and behavioural 3x3 engine around the scheduler
module tb_conv3x3_frame_scheduler;
  localparam int DW = 8, IW = 28, AW = 16, FW = 8, LAT = 2;
  localparam int IN_PIX = IW * IW, OUT_PIX = (IW - 2) * (IW - 2), OW = IW - 2;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0;
  logic [FW-1:0] num_frames = '0;
  logic busy, done, error, src_rd_en, eng_rst_n, eng_valid_in, dst_wr_en, eng_valid_out;
  logic [AW-1:0] src_rd_addr, dst_wr_addr;
  logic [DW-1:0] src_rd_data = '0, eng_pixel_in, dst_wr_data, eng_pixel_out, po = '0;
  logic vo = 1'b0;
  bit mute = 0, inject = 0;
  assign eng_valid_out = vo & ~mute;
  assign eng_pixel_out = po;
  typedef struct packed {logic [AW-1:0] a; logic [DW-1:0] d;} wr_t;
  typedef struct {int due; logic [DW-1:0] v;} ev_t;
  wr_t exp_q[$];
  bit exp_done_q[$];
  int lows[$], rd_starts[$];
  ev_t pend[$];
  wr_t we;
  logic [DW-1:0] src_mem [65536];
  logic [DW-1:0] img [IN_PIX];
  int checks = 0, passes = 0, cyc = 0, rd_cnt = 0, wr_cnt = 0, done_cnt = 0;
  int last_rd = 0, done_cyc = 0, low_run = 0, ecnt = 0, ocnt = 0, er = 0, ec = 0;
  bit prev_rd = 0, extra = 0;

  conv3x3_frame_scheduler dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .num_frames(num_frames),
    .busy(busy), .done(done), .error(error),
    .src_rd_en(src_rd_en), .src_rd_addr(src_rd_addr), .src_rd_data(src_rd_data),
    .eng_rst_n(eng_rst_n), .eng_valid_in(eng_valid_in), .eng_pixel_in(eng_pixel_in),
    .eng_valid_out(eng_valid_out), .eng_pixel_out(eng_pixel_out),
    .dst_wr_en(dst_wr_en), .dst_wr_addr(dst_wr_addr), .dst_wr_data(dst_wr_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic logic [DW-1:0] lap(input int c, input int n, input int s, input int w, input int e);
    return DW'(4 * c - n - s - w - e);
  endfunction

  function automatic int px(input int b, input int r, input int c);
    return int'(src_mem[b + r * IW + c]);
  endfunction

  task automatic push_frames(input int nf);
    for (int f = 0; f < nf; f++)
      for (int k = 0; k < OUT_PIX; k++) begin
        int r, c, b;
        r = k / OW + 1;
        c = k % OW + 1;
        b = f * IN_PIX;
        exp_q.push_back('{a: AW'(f * OUT_PIX + k),
                          d: lap(px(b, r, c), px(b, r - 1, c), px(b, r + 1, c), px(b, r, c - 1), px(b, r, c + 1))});
      end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_pulse(input int n);
    start = 1'b1;
    num_frames = FW'(n);
    tick;
    start = 1'b0;
  endtask

  task automatic wait_done(input int max, input string name);
    int d0, i;
    d0 = done_cnt;
    i = 0;
    while (done_cnt == d0 && i < max) begin
      tick;
      i++;
    end
    if (done_cnt == d0) begin
      check({name, "_done_timeout"}, 0, 1);
      abort = 1'b1;
      tick;
      abort = 1'b0;
    end
  endtask

  initial forever begin
    @(posedge clk);
    if (src_rd_en) src_rd_data <= src_mem[src_rd_addr];
  end

  // behavioural engine: Laplacian-style kernel, fixed latency, cleared by eng_rst_n
  initial forever begin
    @(posedge clk);
    vo <= 1'b0;
    if (!eng_rst_n) begin
      ecnt = 0;
      ocnt = 0;
      extra = 0;
      pend.delete();
    end else begin
      if (eng_valid_in && ecnt < IN_PIX) begin
        img[ecnt] = eng_pixel_in;
        if (ecnt / IW >= 2 && ecnt % IW >= 2) begin
          er = ecnt / IW - 1;
          ec = ecnt % IW - 1;
          pend.push_back('{cyc + LAT, lap(int'(img[er*IW+ec]), int'(img[(er-1)*IW+ec]), int'(img[(er+1)*IW+ec]),
                                          int'(img[er*IW+ec-1]), int'(img[er*IW+ec+1]))});
        end
        ecnt++;
      end
      if (extra) begin
        vo <= 1'b1;
        po <= 8'hAA;
        extra = 0;
      end else if (pend.size() > 0 && pend[0].due <= cyc) begin
        vo <= 1'b1;
        po <= pend[0].v;
        void'(pend.pop_front());
        ocnt++;
        extra = inject && ocnt == OUT_PIX;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (dst_wr_en) begin
      wr_cnt++;
      if (exp_q.size() == 0) check("dst_extra_write", dst_wr_addr, -1);
      else begin
        we = exp_q.pop_front();
        check("dst_addr", dst_wr_addr, we.a);
        check("dst_data", dst_wr_data, we.d);
      end
    end
    if (src_rd_en) begin
      rd_cnt++;
      last_rd = cyc;
      if (!prev_rd) rd_starts.push_back(int'(src_rd_addr));
    end
    prev_rd = src_rd_en;
    if (!eng_rst_n) low_run++;
    else if (low_run > 0) begin
      lows.push_back(low_run);
      low_run = 0;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      if (exp_done_q.size() == 0) check("unexpected_done", 1, 0);
      else check("done_error", error, exp_done_q.pop_front());
      check("writes_left_at_done", exp_q.size(), 0);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int rd0, wr0, d0;
    for (int i = 0; i < 65536; i++) src_mem[i] = DW'($urandom);
    repeat (3) tick;
    check("rst_eng_rst_n", eng_rst_n, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_src_rd_en", src_rd_en, 0);
    check("rst_eng_valid_in", eng_valid_in, 0);
    check("rst_dst_wr_en", dst_wr_en, 0);
    rst = 1'b0;
    repeat (2) tick;
    check("idle_eng_rst_n", eng_rst_n, 1);
    lows.delete();
    rd_starts.delete();

    rd0 = rd_cnt; wr0 = wr_cnt;
    push_frames(1);
    exp_done_q.push_back(0);
    start_pulse(1);
    check("t1_busy", busy, 1);
    wait_done(5000, "t1");
    check("t1_busy_after", busy, 0);
    check("t1_reads", rd_cnt - rd0, IN_PIX);
    check("t1_writes", wr_cnt - wr0, OUT_PIX);
    check("t1_flush_runs", lows.size(), 1);
    check("t1_flush_len", lows.size() > 0 ? lows[0] : -1, 2);

    for (int i = 0; i < IN_PIX; i++) src_mem[2 * IN_PIX + i] = src_mem[i];
    lows.delete(); rd_starts.delete();
    rd0 = rd_cnt; wr0 = wr_cnt;
    push_frames(3);
    exp_done_q.push_back(0);
    start_pulse(3);
    repeat (100) tick;
    start_pulse(1);
    check("t5_busy_mid", busy, 1);
    wait_done(12000, "t2");
    check("t2_reads", rd_cnt - rd0, 3 * IN_PIX);
    check("t2_writes", wr_cnt - wr0, 3 * OUT_PIX);
    for (int i = 0; i < 3; i++) begin
      check("t2_src_base", rd_starts.size() > i ? rd_starts[i] : -1, i * IN_PIX);
      check("t2_flush_len", lows.size() > i ? lows[i] : -1, 2);
    end
    check("t2_flush_runs", lows.size(), 3);

    wr0 = wr_cnt;
    mute = 1;
    exp_done_q.push_back(1);
    start_pulse(1);
    wait_done(6000, "t3");
    mute = 0;
    check("t3_watchdog_latency", done_cyc - last_rd, 4097);
    check("t3_writes", wr_cnt - wr0, 0);
    tick;
    check("t3_error_sticky", error, 1);

    rd0 = rd_cnt; wr0 = wr_cnt;
    exp_done_q.push_back(0);
    start = 1'b1; num_frames = '0;
    tick;
    start = 1'b0;
    check("t5_zero_done", done, 1);
    check("t5_zero_error", error, 0);
    check("t5_zero_busy", busy, 0);
    tick;
    check("t5_zero_done_pulse", done, 0);
    check("t5_zero_reads", rd_cnt - rd0, 0);
    check("t5_zero_writes", wr_cnt - wr0, 0);

    d0 = done_cnt;
    push_frames(1);
    start_pulse(1);
    for (int i = 0; i < 3000 && !(src_rd_en && src_rd_addr == 300); i++) tick;
    check("t4_reach_300", src_rd_addr, 300);
    abort = 1'b1;
    tick;
    abort = 1'b0;
    check("t4_busy", busy, 0);
    check("t4_eng_rst_n", eng_rst_n, 0);
    exp_q.delete();
    repeat (20) tick;
    check("t4_no_done", done_cnt, d0);
    check("t4_eng_rst_n_back", eng_rst_n, 1);
    wr0 = wr_cnt;
    push_frames(1);
    exp_done_q.push_back(0);
    start_pulse(1);
    wait_done(5000, "t4_rerun");
    check("t4_rerun_writes", wr_cnt - wr0, OUT_PIX);

    wr0 = wr_cnt;
    inject = 1;
    push_frames(1);
    exp_done_q.push_back(1);
    start_pulse(1);
    wait_done(5000, "t6");
    inject = 0;
    check("t6_writes", wr_cnt - wr0, OUT_PIX);
    check("t6_error", error, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
